// File: rtl/rf_wb_arbiter.sv
// rf_wb_arbiter: round-robin write-back arbiter for the single write port
// of the 32x32 register file. Requesters hand over (address, data) pairs
// on valid/ready handshakes; the winner is registered onto wa/we/wd one
// cycle later. Writes to x0 are accepted but never enabled. wr_cnt counts
// committed (we=1) writes and wraps at 16 bits.
//
// Optional build macro RF_WB_FWD_EN adds three read-port bypass muxes
// (ra*/rf_rd* -> fwd_rd*) that return the pending write data when a read
// address matches the registered write address.
module rf_wb_arbiter #(
    parameter int WIDTH = 32,
    parameter int NREQ  = 3
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  hold,
    input  logic [NREQ-1:0]       req_valid,
    output logic [NREQ-1:0]       req_ready,
    input  logic [5*NREQ-1:0]     req_wa,
    input  logic [WIDTH*NREQ-1:0] req_wd,
    output logic [4:0]            wa,
    output logic                  we,
    output logic [WIDTH-1:0]      wd,
    output logic [15:0]           wr_cnt
`ifdef RF_WB_FWD_EN
    ,
    input  logic [4:0]            ra0,
    input  logic [4:0]            ra1,
    input  logic [4:0]            ra2,
    input  logic [WIDTH-1:0]      rf_rd0,
    input  logic [WIDTH-1:0]      rf_rd1,
    input  logic [WIDTH-1:0]      rf_rd2,
    output logic [WIDTH-1:0]      fwd_rd0,
    output logic [WIDTH-1:0]      fwd_rd1,
    output logic [WIDTH-1:0]      fwd_rd2
`endif
);

    localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;

    logic [PW-1:0]    rr_ptr_r;
    logic [PW-1:0]    gidx_s;
    logic [PW-1:0]    next_ptr_s;
    logic             found_s;
    logic             grant_en_s;
    logic [NREQ-1:0]  ready_s;
    logic [4:0]       sel_wa_s;
    logic [WIDTH-1:0] sel_wd_s;
    logic             sel_nz_s;

    logic [4:0]       wa_r;
    logic             we_r;
    logic [WIDTH-1:0] wd_r;
    logic [15:0]      wr_cnt_r;

    // Circular search from rr_ptr for the first valid requester.
    always_comb begin
        int cand;
        int wrapped;
        logic hit;
        found_s = 1'b0;
        gidx_s  = '0;
        cand    = 0;
        wrapped = 0;
        hit     = 1'b0;
        for (int k = 0; k < NREQ; k++) begin
            cand    = int'(rr_ptr_r) + k;
            wrapped = (cand >= NREQ) ? (cand - NREQ) : cand;
            hit     = req_valid[wrapped[PW-1:0]] & ~found_s;
            gidx_s  = hit ? wrapped[PW-1:0] : gidx_s;
            found_s = found_s | req_valid[wrapped[PW-1:0]];
        end
    end

    // Grant decode, winner payload mux and next pointer; grants are
    // suppressed during reset and hold so nothing is consumed then.
    always_comb begin
        grant_en_s = found_s & ~hold & ~rst;
        ready_s    = '0;
        for (int i = 0; i < NREQ; i++) begin
            ready_s[i] = grant_en_s & (gidx_s == PW'(i));
        end
        sel_wa_s   = req_wa[int'(gidx_s)*5 +: 5];
        sel_wd_s   = req_wd[int'(gidx_s)*WIDTH +: WIDTH];
        sel_nz_s   = |sel_wa_s;
        next_ptr_s = (gidx_s == PW'(NREQ-1)) ? '0 : (gidx_s + PW'(1));
    end

    // Output stage, round-robin pointer and commit counter. x0 writes still
    // load wa/wd and advance the pointer, but leave we low.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rr_ptr_r <= '0;
            wa_r     <= 5'd0;
            we_r     <= 1'b0;
            wd_r     <= '0;
            wr_cnt_r <= 16'd0;
        end else if (grant_en_s) begin
            wa_r     <= sel_wa_s;
            wd_r     <= sel_wd_s;
            we_r     <= sel_nz_s;
            rr_ptr_r <= next_ptr_s;
            wr_cnt_r <= sel_nz_s ? (wr_cnt_r + 16'd1) : wr_cnt_r;
        end else begin
            we_r     <= 1'b0;
        end
    end

    assign req_ready = ready_s;
    assign wa        = wa_r;
    assign we        = we_r;
    assign wd        = wd_r;
    assign wr_cnt    = wr_cnt_r;

`ifdef RF_WB_FWD_EN
    // Bypass select: pending write wins over stale file data on address match.
    function automatic logic [WIDTH-1:0] fwd_sel(
        input logic             w_en,
        input logic [4:0]       w_addr,
        input logic [WIDTH-1:0] w_data,
        input logic [4:0]       r_addr,
        input logic [WIDTH-1:0] r_data
    );
        return (w_en && (w_addr == r_addr)) ? w_data : r_data;
    endfunction

    assign fwd_rd0 = fwd_sel(we_r, wa_r, wd_r, ra0, rf_rd0);
    assign fwd_rd1 = fwd_sel(we_r, wa_r, wd_r, ra1, rf_rd1);
    assign fwd_rd2 = fwd_sel(we_r, wa_r, wd_r, ra2, rf_rd2);
`endif

endmodule

// File: tb/tb_rf_wb_arbiter.sv
// tb_rf_wb_arbiter: directed stimulus for rf_wb_arbiter. Each expected
// register-file commit is queued when its request is issued; a negedge
// monitor pops one entry whenever the DUT shows we=1 and compares it.
`timescale 1ns/1ps
module tb_rf_wb_arbiter;

    localparam int WIDTH = 32;
    localparam int NREQ  = 3;

    logic                  clk;
    logic                  rst;
    logic                  hold;
    logic [NREQ-1:0]       req_valid;
    logic [NREQ-1:0]       req_ready;
    logic [5*NREQ-1:0]     req_wa;
    logic [WIDTH*NREQ-1:0] req_wd;
    logic [4:0]            wa;
    logic                  we;
    logic [WIDTH-1:0]      wd;
    logic [15:0]           wr_cnt;
`ifdef RF_WB_FWD_EN
    logic [4:0]            ra0, ra1, ra2;
    logic [WIDTH-1:0]      rf_rd0, rf_rd1, rf_rd2;
    logic [WIDTH-1:0]      fwd_rd0, fwd_rd1, fwd_rd2;
`endif

    typedef struct packed {
        logic [4:0]       addr;
        logic [WIDTH-1:0] data;
        logic [15:0]      cnt;
    } exp_t;

    exp_t exp_q[$];
    int   total = 0;
    int   bad   = 0;

    rf_wb_arbiter #(.WIDTH(WIDTH), .NREQ(NREQ)) dut (
        .clk(clk), .rst(rst), .hold(hold),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_wa(req_wa), .req_wd(req_wd),
        .wa(wa), .we(we), .wd(wd), .wr_cnt(wr_cnt)
`ifdef RF_WB_FWD_EN
        ,
        .ra0(ra0), .ra1(ra1), .ra2(ra2),
        .rf_rd0(rf_rd0), .rf_rd1(rf_rd1), .rf_rd2(rf_rd2),
        .fwd_rd0(fwd_rd0), .fwd_rd1(fwd_rd1), .fwd_rd2(fwd_rd2)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] expv);
        total++;
        if (act !== expv) begin
            bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, expv);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_req(input int i, input logic [4:0] a, input logic [WIDTH-1:0] d);
        req_wa[i*5 +: 5]         = a;
        req_wd[i*WIDTH +: WIDTH] = d;
    endtask

    task automatic push(input logic [4:0] a, input logic [WIDTH-1:0] d, input logic [15:0] c);
        exp_t e;
        e.addr = a;
        e.data = d;
        e.cnt  = c;
        exp_q.push_back(e);
    endtask

    // Monitor: every committed write must match the next queued expectation.
    always @(negedge clk) begin
        if (we === 1'b1) begin
            if (exp_q.size() == 0) begin
                check("unexpected_write", 64'(wa), 64'h1_0000_0000);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                check("commit_wa", 64'(wa), 64'(e.addr));
                check("commit_wd", 64'(wd), 64'(e.data));
                check("commit_cnt", 64'(wr_cnt), 64'(e.cnt));
            end
        end
    end

    initial begin
        int order [6];
        order = '{2, 0, 1, 2, 0, 1};

        rst       = 1'b1;
        hold      = 1'b0;
        req_valid = 3'b111;
        req_wa    = '0;
        req_wd    = '0;
`ifdef RF_WB_FWD_EN
        ra0 = 5'd0; ra1 = 5'd0; ra2 = 5'd0;
        rf_rd0 = '0; rf_rd1 = '0; rf_rd2 = '0;
`endif
        #2;
        check("ready_in_reset", 64'(req_ready), 64'd0);
        step();
        step();
        rst       = 1'b0;
        req_valid = 3'b000;
        #1;
        check("idle_we", 64'(we), 64'd0);
        check("idle_wa", 64'(wa), 64'd0);
        check("idle_wd", 64'(wd), 64'd0);
        check("idle_cnt", 64'(wr_cnt), 64'd0);
        check("idle_ready", 64'(req_ready), 64'd0);

        // Single write from requester 1
        set_req(1, 5'd5, 32'hDEADBEEF);
        req_valid = 3'b010;
        #1;
        check("single_ready", 64'(req_ready), 64'b010);
        push(5'd5, 32'hDEADBEEF, 16'd1);
        step();
        req_valid = 3'b000;
`ifdef RF_WB_FWD_EN
        ra0 = 5'd5; rf_rd0 = 32'h11;
        ra1 = 5'd8; rf_rd1 = 32'h22;
        ra2 = 5'd0; rf_rd2 = 32'h33;
        #1;
        check("fwd_rd0_hit", 64'(fwd_rd0), 64'hDEADBEEF);
        check("fwd_rd1_miss", 64'(fwd_rd1), 64'h22);
        check("fwd_rd2_x0", 64'(fwd_rd2), 64'h33);
`endif

        // Round robin with all valid; pointer starts at 2
        for (int k = 0; k < 3; k++) begin
            set_req(order[k], 5'(k + 1), 32'h100 + 32'(k + 1));
        end
        req_valid = 3'b111;
        for (int k = 0; k < 6; k++) begin
            #1;
            check("rr_ready", 64'(req_ready), 64'(3'b001 << order[k]));
            push(5'(k + 1), 32'h100 + 32'(k + 1), 16'(k + 2));
            step();
            if (k + 3 < 6) begin
                set_req(order[k], 5'(k + 4), 32'h100 + 32'(k + 4));
            end
        end
        req_valid = 3'b000;

        // x0 write: accepted, loads wa/wd, no enable, no count
        set_req(0, 5'd0, 32'h1);
        req_valid = 3'b001;
        #1;
        check("x0_ready", 64'(req_ready), 64'b001);
        step();
        check("x0_we", 64'(we), 64'd0);
        check("x0_wa", 64'(wa), 64'd0);
        check("x0_wd", 64'(wd), 64'd1);
        check("x0_cnt", 64'(wr_cnt), 64'd7);

        // Same address from requesters 1 and 2: grant order decides
        set_req(1, 5'd7, 32'hA);
        set_req(2, 5'd7, 32'hB);
        req_valid = 3'b110;
        #1;
        check("same_ready1", 64'(req_ready), 64'b010);
        push(5'd7, 32'hA, 16'd8);
        step();
        req_valid = 3'b100;
        #1;
        check("same_ready2", 64'(req_ready), 64'b100);
        push(5'd7, 32'hB, 16'd9);
        step();
        req_valid = 3'b000;

        // Hold with all valid, then release at frozen pointer 0
        set_req(0, 5'd10, 32'h200);
        set_req(1, 5'd11, 32'h201);
        set_req(2, 5'd12, 32'h202);
        req_valid = 3'b111;
        hold      = 1'b1;
        #1;
        check("hold_ready", 64'(req_ready), 64'd0);
        step();
        check("hold_we", 64'(we), 64'd0);
        hold = 1'b0;
        #1;
        check("resume_ready", 64'(req_ready), 64'b001);
        push(5'd10, 32'h200, 16'd10);
        step();
        req_valid = 3'b110;
        hold      = 1'b1;
        #1;
        check("midhold_ready", 64'(req_ready), 64'd0);
        check("midhold_we_commits", 64'(we), 64'd1);
        step();
        check("midhold_we_off", 64'(we), 64'd0);
        hold = 1'b0;
        #1;
        check("after_hold_ready", 64'(req_ready), 64'b010);
        step();
        check("pending_we", 64'(we), 64'd1);
        check("pending_wa", 64'(wa), 64'd11);
        check("pending_cnt", 64'(wr_cnt), 64'd11);

        // Async reset between edges discards the pending write
        req_valid = 3'b100;
        #1;
        rst = 1'b1;
        #1;
        check("rst_we", 64'(we), 64'd0);
        check("rst_wa", 64'(wa), 64'd0);
        check("rst_cnt", 64'(wr_cnt), 64'd0);
        check("rst_ready", 64'(req_ready), 64'd0);
        rst = 1'b0;
        #1;
        check("post_rst_ready", 64'(req_ready), 64'b100);
        push(5'd12, 32'h202, 16'd1);
        step();
        req_valid = 3'b000;
        step();
        step();
        step();
        check("queue_drained", 64'(exp_q.size()), 64'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
